// File: rtl/dma_sched.sv
// dma_sched: shares the DMA engine's port interface between Z80 writes and
// two hardware channels. An idle scheduler forwards Z80 strobes. A granted
// channel has its 9-byte descriptor replayed as one strobe per cycle,
// with the launch strobe last. The scheduler then waits for the engine to
// go idle before it reports completion.
// Optional feature: define DMA_SCHED_RR_EN for round-robin arbitration.
// If the macro is undefined, channel 0 has fixed priority over channel 1.
module dma_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  z_wr,
  input  logic [7:0]  z_data,
  input  logic [1:0]  ch_req,
  input  logic [71:0] ch_desc0,
  input  logic [71:0] ch_desc1,
  input  logic        dma_act,
  output logic [8:0]  dmaport_wr,
  output logic [7:0]  dma_zdata,
  output logic [1:0]  ch_ack,
  output logic [1:0]  ch_done,
  output logic        busy,
  output logic        z_drop,
  input  logic        z_drop_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int unsigned NBYTES   = 9;
  localparam logic [3:0]  LAST_IDX = 4'd8;  // sequence position of the launch strobe
  localparam logic [1:0]  GUARD    = 2'd2;  // RUN cycles in which dma_act is not trusted

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  guard_q, guard_d;
  logic [71:0] desc_q, desc_d;
  logic        owner_q, owner_d;
  logic [8:0]  wr_q, wr_d;
  logic [7:0]  zdata_q, zdata_d;
  logic [1:0]  ack_q, ack_d;
  logic        drop_q, drop_d;
  logic [1:0]  done_c;

  logic        grant_ch;
  logic [71:0] win_desc;
  logic [1:0]  owner_oh;
  logic [7:0]  desc_byte [NBYTES];

`ifdef DMA_SCHED_RR_EN
  logic rr_q, rr_d;
`endif

  // Split the latched descriptor into its byte lanes.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign desc_byte[gi] = desc_q[8*gi +: 8];
    end
  endgenerate

  // Sequence position to descriptor byte. Bytes 7 (launch) and 8 (num) are
  // swapped so that the launch strobe is always the last one issued.
  function automatic logic [3:0] seq_byte(input logic [3:0] pos);
    logic [3:0] b;
    if (pos == 4'd7)      b = 4'd8;
    else if (pos == 4'd8) b = 4'd7;
    else                  b = pos;
    return b;
  endfunction

`ifdef DMA_SCHED_RR_EN
  // Round-robin: prefer the channel named by the pointer, else take the other.
  always_comb begin
    if (ch_req[rr_q]) grant_ch = rr_q;
    else              grant_ch = ~rr_q;
  end
`else
  // Fixed priority: channel 0 wins whenever it requests.
  always_comb begin
    grant_ch = ~ch_req[0];
  end
`endif

  assign win_desc = grant_ch ? ch_desc1 : ch_desc0;
  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  // Next-state logic for the scheduler FSM. It also prepares the strobe,
  // data and ack values that appear in the next cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    guard_d = guard_q;
    desc_d  = desc_q;
    owner_d = owner_q;
    wr_d    = '0;
    zdata_d = zdata_q;
    ack_d   = '0;
    done_c  = '0;
    drop_d  = drop_q & ~z_drop_clr;
`ifdef DMA_SCHED_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (z_wr != 9'd0) begin
          // A Z80 write has priority and pushes any grant back by a cycle.
          wr_d    = z_wr;
          zdata_d = z_data;
        end else if ((ch_req != 2'b00) && !dma_act) begin
          // Grant. Byte 0 is issued straight from the winner's descriptor,
          // so the strobes line up with the cycles spent in LOAD.
          owner_d = grant_ch;
          desc_d  = win_desc;
          idx_d   = '0;
          wr_d    = 9'd1;
          zdata_d = win_desc[7:0];
          state_d = LOAD;
`ifdef DMA_SCHED_RR_EN
          rr_d    = ~grant_ch;
`endif
        end
      end
      LOAD: begin
        if (idx_q == LAST_IDX) begin
          state_d = RUN;
          guard_d = '0;
        end else begin
          idx_d   = idx_q + 4'd1;
          wr_d    = 9'd1 << seq_byte(idx_d);
          zdata_d = desc_byte[seq_byte(idx_d)];
          if (idx_d == LAST_IDX) begin
            ack_d = owner_oh;
          end
        end
      end
      RUN: begin
        if (guard_q != GUARD) begin
          guard_d = guard_q + 2'd1;
        end else if (!dma_act) begin
          done_c  = owner_oh;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A Z80 write is lost while a channel owns the port. A new drop
    // overrides a clear in the same cycle.
    if ((state_q != IDLE) && (z_wr != 9'd0)) begin
      drop_d = 1'b1;
    end
  end

  // State and output registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      guard_q <= '0;
      desc_q  <= '0;
      owner_q <= 1'b0;
      wr_q    <= '0;
      zdata_q <= '0;
      ack_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
      desc_q  <= desc_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      zdata_q <= zdata_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
    end
  end

`ifdef DMA_SCHED_RR_EN
  // Round-robin pointer; it moves only on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  assign dmaport_wr = wr_q;
  assign dma_zdata  = zdata_q;
  assign ch_ack     = ack_q;
  assign ch_done    = done_c;
  assign busy       = (state_q != IDLE);
  assign z_drop     = drop_q;

endmodule
